req_send_ctrl: RTL

- Producer stage that generates the req_data → ready/d → done/q transfer and the req → ack handshake consumed by the downstream protocol-checker block.
- Captures a 16-bit word on a req_data rising edge and presents it on d with a one-cycle ready pulse.
- Captures a second word at the ready cycle and returns it on q with a one-cycle done pulse.
- Services an independent req/ack channel with a programmable max_count timeout.

---
 rtl/req_send_pkg.sv | 17 +
 rtl/req_send_ctrl_rise_det.sv | 22 ++
 rtl/req_send_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/req_send_pkg.sv
// Shared types and constants for the request-send producer stage.
package req_send_pkg;

  localparam int DW_DEF       = 16;
  localparam int CW_DEF       = 32;
  localparam int RDY_LAT_MAX  = 2;
  localparam int DONE_LAT_MIN = 1;
  localparam int DONE_LAT_MAX = 5;
  localparam int LAT_W        = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RDY_WAIT  = 2'd1,
    DONE_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/req_send_ctrl_rise_det.sv
// Rising-edge detector: one flop plus AND-NOT, flop always tracks the input.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_r;

  // previous-cycle copy of the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= 1'b0;
    end else begin
      sig_r <= sig;
    end
  end

  assign rise = sig & ~sig_r;

endmodule

// File: rtl/req_send_ctrl.sv
// Producer stage: req_data -> ready/d -> done/q transfer plus req -> ack
// handshake with a max_count timeout. All outputs come straight from flops.
module req_send_ctrl
  import req_send_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int RDY_LAT  = 2,
  parameter int DONE_LAT = 3,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_data,
  input  logic [DW-1:0] data,
  input  logic          req,
  input  logic [CW-1:0] max_count,
  output logic          ready,
  output logic [DW-1:0] d,
  output logic          done,
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          ack,
  output logic          timeout
);

  if (RDY_LAT < 0 || RDY_LAT > RDY_LAT_MAX) begin : g_bad_rdy_lat
    $error("req_send_ctrl: RDY_LAT out of range");
  end
  if (DONE_LAT < DONE_LAT_MIN || DONE_LAT > DONE_LAT_MAX) begin : g_bad_done_lat
    $error("req_send_ctrl: DONE_LAT out of range");
  end

  localparam logic [LAT_W-1:0] LAT_ZERO    = 3'd0;
  localparam logic [LAT_W-1:0] LAT_ONE     = 3'd1;
  localparam logic [LAT_W-1:0] RDY_LAT_V   = LAT_W'(RDY_LAT);
  localparam logic [LAT_W-1:0] DONE_LAT_M1 = LAT_W'(DONE_LAT - 1);
  localparam logic [CW-1:0]    CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_MAX     = {CW{1'b1}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic data_rise_s, req_rise_s;

  rise_det u_rise_data (.clk(clk), .rst_n(rst_n), .sig(req_data), .rise(data_rise_s));
  rise_det u_rise_req  (.clk(clk), .rst_n(rst_n), .sig(req),      .rise(req_rise_s));

  state_e           state_r, state_nxt_s;
  logic [LAT_W-1:0] lat_r, lat_nxt_s;
  logic [DW-1:0]    hold1_r, hold1_nxt_s, hold2_r, hold2_nxt_s;
  logic [DW-1:0]    d_r, d_nxt_s, q_r, q_nxt_s;
  logic             ready_r, ready_nxt_s, done_r, done_nxt_s, busy_r, busy_nxt_s;

  // transfer FSM; ready/done are decided one cycle early so they can be registered
  always_comb begin
    state_nxt_s = state_r;
    lat_nxt_s   = lat_r;
    hold1_nxt_s = hold1_r;
    hold2_nxt_s = hold2_r;
    d_nxt_s     = d_r;
    q_nxt_s     = q_r;
    ready_nxt_s = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_rise_s) begin
          hold1_nxt_s = data;
          lat_nxt_s   = RDY_LAT_V;
          state_nxt_s = RDY_WAIT;
          if (RDY_LAT_V == LAT_ZERO) begin
            ready_nxt_s = 1'b1;
            d_nxt_s     = data;
          end else begin
            ready_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RDY_WAIT: begin
        if (lat_r == LAT_ZERO) begin
          // this is the ready cycle: second word is sampled now
          hold2_nxt_s = data;
          lat_nxt_s   = DONE_LAT_M1;
          state_nxt_s = DONE_WAIT;
          if (DONE_LAT_M1 == LAT_ZERO) begin
            done_nxt_s = 1'b1;
            q_nxt_s    = data;
          end else begin
            done_nxt_s = 1'b0;
          end
        end else begin
          lat_nxt_s = lat_r - LAT_ONE;
          if (lat_r == LAT_ONE) begin
            ready_nxt_s = 1'b1;
            d_nxt_s     = hold1_r;
          end else begin
            ready_nxt_s = 1'b0;
          end
        end
      end
      DONE_WAIT: begin
        if (lat_r == LAT_ZERO) begin
          state_nxt_s = IDLE;
        end else begin
          lat_nxt_s = lat_r - LAT_ONE;
          if (lat_r == LAT_ONE) begin
            done_nxt_s = 1'b1;
            q_nxt_s    = hold2_r;
          end else begin
            done_nxt_s = 1'b0;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // transfer state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      lat_r   <= LAT_ZERO;
      hold1_r <= {DW{1'b0}};
      hold2_r <= {DW{1'b0}};
      d_r     <= {DW{1'b0}};
      q_r     <= {DW{1'b0}};
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      lat_r   <= lat_nxt_s;
      hold1_r <= hold1_nxt_s;
      hold2_r <= hold2_nxt_s;
      d_r     <= d_nxt_s;
      q_r     <= q_nxt_s;
      ready_r <= ready_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  logic          armed_r, armed_nxt_s, ack_r, ack_nxt_s, to_r, to_nxt_s;
  logic          eval_s, limit_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s, k_s;

  // ack channel: k_s is the cycle count that will hold in the next cycle
  always_comb begin
    armed_nxt_s = armed_r;
    cnt_nxt_s   = cnt_r;
    ack_nxt_s   = 1'b0;
    to_nxt_s    = 1'b0;
    eval_s      = 1'b0;
    k_s         = cnt_r;
    if (req_rise_s) begin
      eval_s = 1'b1;
      k_s    = CNT_ONE;
    end else if (armed_r) begin
      eval_s = 1'b1;
      k_s    = sat_inc(cnt_r);
    end else begin
      eval_s = 1'b0;
    end
    limit_s = ({1'b0, k_s} + {1'b0, CNT_ONE}) >= {1'b0, max_count};
    if (eval_s && (done_nxt_s || limit_s)) begin
      ack_nxt_s   = 1'b1;
      to_nxt_s    = ~done_nxt_s;
      armed_nxt_s = 1'b0;
    end else if (eval_s) begin
      armed_nxt_s = 1'b1;
      cnt_nxt_s   = k_s;
    end else begin
      armed_nxt_s = 1'b0;
    end
  end

  // ack channel registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      ack_r   <= 1'b0;
      to_r    <= 1'b0;
    end else begin
      armed_r <= armed_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= ack_nxt_s;
      to_r    <= to_nxt_s;
    end
  end

  assign ready   = ready_r;
  assign d       = d_r;
  assign done    = done_r;
  assign q       = q_r;
  assign busy    = busy_r;
  assign ack     = ack_r;
  assign timeout = to_r;

endmodule
